alu_share_arbiter: RTL
======================

Name: alu_share_arbiter

Overview:
- Shares the single registered 32-bit ALU between two requesters, e.g. the main execute path (port 0) and the branch/address-generation path (port 1).
- Arbitrates round-robin with a valid/ready request handshake and drives the ALU operand and control inputs.
- Tracks the ALU's one-cycle result latency and returns each result to its originator through a held valid/ready response port.
- Each requester may have at most one operation outstanding.

Parameters:
- WIDTH, 32, operand and result width; must match the ALU.
- CTRL_W, 4, ALU control field width; passed through unmodified.

Ports:
- clk  in  1  clock.
- resetn  in  1  synchronous active-low reset; same net as the ALU's resetn.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_a  in  WIDTH  operand a.
- req0_b  in  WIDTH  operand b.
- req0_op  in  CTRL_W  ALU control code.
- rsp0_valid  out  1  requester 0 result available.
- rsp0_ready  in  1  requester 0 consumes result.
- rsp0_result  out  WIDTH  result for requester 0.
- req1_valid, req1_ready, req1_a, req1_b, req1_op, rsp1_valid, rsp1_ready, rsp1_result: same as port 0, for requester 1.
- alu_a  out  WIDTH  to ALU a.
- alu_b  out  WIDTH  to ALU b.
- alu_control  out  CTRL_W  to ALU control.
- alu_result  in  WIDTH  from ALU result; registered inside the ALU, valid one cycle after issue.

Behaviour:
- Clock and reset: clk is the clock; resetn is synchronous, active-low.
- State per port i:
  - busy_i: set on grant, cleared on the rsp_i handshake.
  - rsp_valid_i and rsp_data_i registers.
- Shared state:
  - inflight_v and inflight_id: one-deep tag matching the ALU pipeline stage.
  - last_grant (1 bit).
- Eligibility: port i is eligible when reqi_valid && !busy_i.
- Grant (combinational, cycle N):
  - Only one eligible port: grant it.
  - Both eligible: grant the port != last_grant.
  - reqi_ready = grant_i.
- Request handshake rule: a requester holds valid, a, b and op stable until ready; the arbiter never drops an asserted request.
- ALU drive (combinational):
  - On a grant, alu_a/alu_b/alu_control = granted port's a/b/op.
  - With no grant, all three are driven 0. The ALU result produced for an idle cycle is ignored.
- Clock edge ending cycle N with a grant:
  - busy_g <= 1.
  - last_grant <= g.
  - inflight_v <= 1, inflight_id <= g.
- Clock edge ending cycle N with no grant: inflight_v <= 0.
- Cycle N+1: alu_result holds the granted op's result. At the edge ending N+1, if inflight_v: rsp_data_id <= alu_result and rsp_valid_id <= 1.
- Cycle N+2: rspi_valid = 1 and rspi_result = rsp_data_i, held stable until rspi_ready.
- Fixed latency: grant to rsp_valid is 2 cycles.
- Response handshake: on rspi_valid && rspi_ready, rsp_valid_i <= 0 and busy_i <= 0. The port becomes eligible in the next cycle, never the same cycle.
- Throughput:
  - The ALU can accept one grant per cycle, alternating ports.
  - A single port issues at most one op every 3 cycles when rsp_ready is held high.
- Simultaneous events:
  - A capture into rsp_i cannot coincide with rsp_valid_i already set, because busy guarantees one outstanding op per port. An implementation assertion checks this.
  - A grant to port j in the same cycle as the rsp_i handshake is legal.
- Reset values (resetn low at an edge):
  - busy_0/1 = 0, rsp_valid_0/1 = 0, rsp_data = 0, inflight_v = 0, inflight_id = 0.
  - last_grant = 1, so port 0 wins the first tie.
  - Outputs: req*_ready = 0 and all alu_* = 0 while resetn is low; rsp*_valid = 0 and rsp*_result = 0.
- Reset mid-operation: in-flight and pending results are discarded. The ALU also resets, so no stale capture occurs after reset is released.
- Width rule: results pass through unmodified; no width or sign handling in this block.

Test Plan:
- Single op: port 0 requests a=5, b=3, op=0000 (add) at cycle 0 -> req0_ready=1 at cycle 0; rsp0_valid=1 with rsp0_result=8 at cycle 2; rsp0_ready=1 there -> rsp0_valid=0 at cycle 3.
- Tie and alternation:
  - Stimulus: both ports valid from reset release. Port 0: a=10, b=4, op=0001. Port 1: a=6, b=3, op=0100. Both rsp_ready=1.
  - Expected: grants go 0 at cycle 0, then 1 at cycle 1.
  - Expected: rsp0_result=6 at cycle 2; rsp1_result=2 at cycle 3.
- Backpressure:
  - Stimulus: port 1 op a=0xF0, b=0x0F, op=0011; rsp1_ready held 0 for 5 cycles while req1_valid stays high with a new op.
  - Expected: rsp1_result=0xFF held stable; req1_ready=0 throughout.
  - Expected: after rsp1_ready=1, req1_ready=1 one cycle later.
- Starvation freedom: both ports continuously valid with rsp_ready=1 for 20 cycles -> grant counts differ by at most 1; no port waits more than 2 consecutive eligible cycles.
- Reset mid-flight: grant port 0 (a=1, b=1, add), assert resetn=0 at cycle 1 for 1 cycle -> no rsp0_valid ever appears for that op; after release, a new port 0 op a=2, b=2 returns 4 with 2-cycle latency.
- Idle: no requests for 10 cycles -> alu_a=alu_b=alu_control=0, and no rsp_valid is asserted.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one registered ALU between two requesters. Each result
// is tagged with its originator and returned on that port's response channel.
module alu_share_arbiter #(
  parameter int WIDTH  = 32,
  parameter int CTRL_W = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [WIDTH-1:0]  req0_a,
  input  logic [WIDTH-1:0]  req0_b,
  input  logic [CTRL_W-1:0] req0_op,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic [WIDTH-1:0]  rsp0_result,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [WIDTH-1:0]  req1_a,
  input  logic [WIDTH-1:0]  req1_b,
  input  logic [CTRL_W-1:0] req1_op,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [WIDTH-1:0]  rsp1_result,
  output logic [WIDTH-1:0]  alu_a,
  output logic [WIDTH-1:0]  alu_b,
  output logic [CTRL_W-1:0] alu_control,
  input  logic [WIDTH-1:0]  alu_result
);

  // Handshakes: a transfer happens on a cycle where valid && ready; the source
  // keeps valid and payload stable until then, and ready never depends on a
  // dropped request.
  logic             busy0, busy1;
  logic             rsp_v0, rsp_v1;
  logic [WIDTH-1:0] rsp_d0, rsp_d1;
  logic             inflight_v, inflight_id;
  logic             last_grant;
  logic             elig0, elig1;
  logic             grant0, grant1;
  logic             hs0, hs1;

  assign elig0 = resetn && req0_valid && !busy0;
  assign elig1 = resetn && req1_valid && !busy1;

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (elig0 && elig1) begin
      grant0 = last_grant;
      grant1 = !last_grant;
    end else begin
      grant0 = elig0;
      grant1 = elig1;
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  always_comb begin
    alu_a       = '0;
    alu_b       = '0;
    alu_control = '0;
    if (grant0) begin
      alu_a       = req0_a;
      alu_b       = req0_b;
      alu_control = req0_op;
    end else if (grant1) begin
      alu_a       = req1_a;
      alu_b       = req1_b;
      alu_control = req1_op;
    end
  end

  assign hs0 = rsp_v0 && rsp0_ready;
  assign hs1 = rsp_v1 && rsp1_ready;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      busy0       <= 1'b0;
      busy1       <= 1'b0;
      rsp_v0      <= 1'b0;
      rsp_v1      <= 1'b0;
      rsp_d0      <= '0;
      rsp_d1      <= '0;
      inflight_v  <= 1'b0;
      inflight_id <= 1'b0;
      last_grant  <= 1'b1;
    end else begin
      if (hs0) begin
        rsp_v0 <= 1'b0;
        busy0  <= 1'b0;
      end
      if (hs1) begin
        rsp_v1 <= 1'b0;
        busy1  <= 1'b0;
      end
      if (grant0) busy0 <= 1'b1;
      if (grant1) busy1 <= 1'b1;
      if (grant0 || grant1) begin
        inflight_v  <= 1'b1;
        inflight_id <= grant1;
        last_grant  <= grant1;
      end else begin
        inflight_v <= 1'b0;
      end
      // The ALU output now belongs to the op issued last cycle.
      if (inflight_v) begin
        if (inflight_id) begin
          rsp_d1 <= alu_result;
          rsp_v1 <= 1'b1;
        end else begin
          rsp_d0 <= alu_result;
          rsp_v0 <= 1'b1;
        end
      end
    end
  end

  assign rsp0_valid  = rsp_v0;
  assign rsp1_valid  = rsp_v1;
  assign rsp0_result = rsp_d0;
  assign rsp1_result = rsp_d1;

  a_no_capture_overrun: assert property (@(posedge clk) disable iff (!resetn)
    inflight_v |-> !(inflight_id ? rsp_v1 : rsp_v0));

endmodule
